// File: rtl/mem_issue_bank_pkg.sv
// Shared backend types for the memory issue bank: entry/ROB position records and
// the wrap-aware ROB ordering helper used when flushing on redirect.
package mem_issue_bank_pkg;

  localparam int unsigned MI_PREG_W = 7;
  localparam int unsigned MI_ROB_W  = 6;

  typedef struct packed {
    logic                dir;
    logic [MI_ROB_W-1:0] idx;
  } RobPos;

  typedef struct packed {
    logic                 valid;
    logic                 rs1v;
    logic                 issued;
    logic [MI_PREG_W-1:0] rs1;
    RobPos                rob;
  } MemIssueEntry;

  // True when ROB position a sits at or before b; dir flips on each ROB wrap.
  function automatic logic rob_older_eq(input logic a_dir, input logic [31:0] a_idx,
                                        input logic b_dir, input logic [31:0] b_idx);
    return (a_dir == b_dir) ? (a_idx <= b_idx) : (a_idx > b_idx);
  endfunction

endpackage

// File: rtl/mem_issue_bank_age_matrix_select.sv
// Age matrix for the issue bank: tracks relative entry age and picks the oldest
// ready entry as a one-hot vector plus encoded index.
module age_matrix_select
  import mem_issue_bank_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_en,
  input  logic [IW-1:0]    enq_slot,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] sel_oh,
  output logic [IW-1:0]    sel_idx,
  output logic             sel_any
);

  // age_q[i][j] set means entry i is older than entry j
  logic [DEPTH-1:0] age_q [DEPTH];
  logic             blocked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (enq_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (IW'(i) == enq_slot) age_q[i] <= '0;
        else if (valid[i])      age_q[i][enq_slot] <= 1'b1;
      end
    end
  end

  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    blocked = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++) blocked = blocked | (ready[j] & age_q[j][i]);
      sel_oh[i] = ready[i] & ~blocked;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) sel_idx = IW'(i);
    end
  end

  assign sel_any = |ready;

endmodule

// File: rtl/mem_issue_bank.sv
// Age-ordered issue bank between dispatch and one memory pipeline issue port.
// Optional macro REPLAY_BACKOFF_EN builds per-entry slow-replay backoff counters.
module mem_issue_bank
  import mem_issue_bank_pkg::*;
#(
  parameter  int unsigned DEPTH        = 8,
  parameter  int unsigned WB_PORTS     = 4,
  parameter  int unsigned PREG_W       = 7,
  parameter  int unsigned ROB_W        = 6,
  parameter  int unsigned PAYLOAD_W    = 64,
  parameter  int unsigned REPLAY_DELAY = 4,
  localparam int unsigned IW           = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic                       enq_rs1v,
  input  logic [PREG_W-1:0]          enq_rs1,
  input  logic                       enq_rob_dir,
  input  logic [ROB_W-1:0]           enq_rob_idx,
  input  logic [PAYLOAD_W-1:0]       enq_payload,
  input  logic [WB_PORTS-1:0]        wb_en,
  input  logic [WB_PORTS*PREG_W-1:0] wb_rd,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [IW-1:0]              issue_idx,
  output logic [PREG_W-1:0]          issue_rs1,
  output logic [PAYLOAD_W-1:0]       issue_payload,
  input  logic                       reply_en,
  input  logic                       reply_slow,
  input  logic [IW-1:0]              reply_idx,
  input  logic                       success_en,
  input  logic [IW-1:0]              success_idx,
  input  logic                       redirect,
  input  logic                       redirect_dir,
  input  logic [ROB_W-1:0]           redirect_idx,
  output logic [IW:0]                count
);

  typedef struct packed {
    logic              valid;
    logic              rs1v;
    logic              issued;
    logic [PREG_W-1:0] rs1;
    logic              dir;
    logic [ROB_W-1:0]  idx;
  } ent_t;

  ent_t                 ent_q [DEPTH];
  ent_t                 ent_d [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];

  logic                 iss_valid_q, iss_valid_d;
  logic [IW-1:0]        iss_idx_q, iss_idx_d;
  logic [PREG_W-1:0]    iss_rs1_q, iss_rs1_d;
  logic [PAYLOAD_W-1:0] iss_pl_q, iss_pl_d;

  logic [DEPTH-1:0] vld, rdy, sel_oh;
  logic [IW-1:0]    enq_slot, sel_idx;
  logic             sel_any, enq_fire, enq_hit, do_sel, hit, found;
  logic [IW:0]      cnt;

`ifdef REPLAY_BACKOFF_EN
  logic [3:0] dly_q [DEPTH];
  logic [3:0] dly_d [DEPTH];
`else
  logic slow_unused;
  assign slow_unused = reply_slow;
`endif

  always_comb begin
    enq_slot = '0;
    found    = 1'b0;
    cnt      = '0;
    enq_hit  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      vld[i] = ent_q[i].valid;
      rdy[i] = ent_q[i].valid & ent_q[i].rs1v & ~ent_q[i].issued
`ifdef REPLAY_BACKOFF_EN
               & (dly_q[i] == 4'd0)
`endif
               ;
      cnt = cnt + {{IW{1'b0}}, ent_q[i].valid};
      if (!ent_q[i].valid && !found) begin
        enq_slot = IW'(i);
        found    = 1'b1;
      end
    end
    for (int unsigned p = 0; p < WB_PORTS; p++)
      enq_hit = enq_hit | (wb_en[p] & (wb_rd[p*PREG_W +: PREG_W] == enq_rs1));
  end

  assign enq_ready = ~&vld;
  assign count     = cnt;
  assign enq_fire  = enq_valid & enq_ready & ~redirect;
  // A reply aimed at the entry being picked this cycle suppresses the pick.
  assign do_sel    = sel_any & (~iss_valid_q | issue_ready) & ~redirect
                     & ~(reply_en & (reply_idx == sel_idx));

  age_matrix_select #(.DEPTH(DEPTH)) u_age (
    .clk      (clk),
    .rst      (rst),
    .enq_en   (enq_fire),
    .enq_slot (enq_slot),
    .valid    (vld),
    .ready    (rdy),
    .sel_oh   (sel_oh),
    .sel_idx  (sel_idx),
    .sel_any  (sel_any)
  );

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      hit      = 1'b0;
      for (int unsigned p = 0; p < WB_PORTS; p++)
        hit = hit | (wb_en[p] & (wb_rd[p*PREG_W +: PREG_W] == ent_q[i].rs1));
      if (ent_q[i].valid && hit) ent_d[i].rs1v = 1'b1;
`ifdef REPLAY_BACKOFF_EN
      dly_d[i] = (dly_q[i] != 4'd0) ? dly_q[i] - 4'd1 : 4'd0;
`endif
      if (redirect) begin
        ent_d[i].valid  = ent_q[i].valid & rob_older_eq(ent_q[i].dir, 32'(ent_q[i].idx),
                                                        redirect_dir, 32'(redirect_idx));
        ent_d[i].issued = 1'b0;
`ifdef REPLAY_BACKOFF_EN
        dly_d[i] = 4'd0;
`endif
      end else begin
        if (do_sel && sel_oh[i]) ent_d[i].issued = 1'b1;
        if (reply_en && reply_idx == IW'(i)) begin
          ent_d[i].issued = 1'b0;
`ifdef REPLAY_BACKOFF_EN
          if (reply_slow) dly_d[i] = 4'(REPLAY_DELAY);
`endif
        end
        if (success_en && success_idx == IW'(i)) ent_d[i].valid = 1'b0;
        if (enq_fire && enq_slot == IW'(i)) begin
          ent_d[i] = '{valid: 1'b1, rs1v: enq_rs1v | enq_hit, issued: 1'b0,
                       rs1: enq_rs1, dir: enq_rob_dir, idx: enq_rob_idx};
`ifdef REPLAY_BACKOFF_EN
          dly_d[i] = 4'd0;
`endif
        end
      end
    end
  end

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_idx_d   = iss_idx_q;
    iss_rs1_d   = iss_rs1_q;
    iss_pl_d    = iss_pl_q;
    if (redirect) begin
      iss_valid_d = 1'b0;
    end else if (do_sel) begin
      iss_valid_d = 1'b1;
      iss_idx_d   = sel_idx;
      iss_rs1_d   = ent_q[sel_idx].rs1;
      iss_pl_d    = payload_q[sel_idx];
    end else if (issue_ready) begin
      iss_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i]     <= '0;
        payload_q[i] <= '0;
      end
      iss_valid_q <= 1'b0;
      iss_idx_q   <= '0;
      iss_rs1_q   <= '0;
      iss_pl_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
        if (enq_fire && enq_slot == IW'(i)) payload_q[i] <= enq_payload;
      end
      iss_valid_q <= iss_valid_d;
      iss_idx_q   <= iss_idx_d;
      iss_rs1_q   <= iss_rs1_d;
      iss_pl_q    <= iss_pl_d;
    end
  end

`ifdef REPLAY_BACKOFF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) dly_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) dly_q[i] <= dly_d[i];
    end
  end
`endif

  assign issue_valid   = iss_valid_q;
  assign issue_idx     = iss_idx_q;
  assign issue_rs1     = iss_rs1_q;
  assign issue_payload = iss_pl_q;

endmodule

// File: tb/tb_mem_issue_bank.sv
// Self-checking bench for mem_issue_bank: issued ops are scored against a queue of
// expected {idx, rs1, payload}; the fill boundary is driven from a vector table.
module tb_mem_issue_bank;

`ifdef REPLAY_BACKOFF_EN
  localparam int BK = 4;
`else
  localparam int BK = 0;
`endif

  logic        clk, rst;
  logic        enq_valid, enq_ready, enq_rs1v, enq_rob_dir;
  logic [6:0]  enq_rs1;
  logic [5:0]  enq_rob_idx;
  logic [63:0] enq_payload;
  logic [3:0]  wb_en;
  logic [27:0] wb_rd;
  logic        issue_valid, issue_ready;
  logic [2:0]  issue_idx;
  logic [6:0]  issue_rs1;
  logic [63:0] issue_payload;
  logic        reply_en, reply_slow, success_en, redirect, redirect_dir;
  logic [2:0]  reply_idx, success_idx;
  logic [5:0]  redirect_idx;
  logic [3:0]  count;

  mem_issue_bank dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_rs1v(enq_rs1v), .enq_rs1(enq_rs1),
    .enq_rob_dir(enq_rob_dir), .enq_rob_idx(enq_rob_idx), .enq_payload(enq_payload),
    .wb_en(wb_en), .wb_rd(wb_rd),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_idx(issue_idx),
    .issue_rs1(issue_rs1), .issue_payload(issue_payload),
    .reply_en(reply_en), .reply_slow(reply_slow), .reply_idx(reply_idx),
    .success_en(success_en), .success_idx(success_idx),
    .redirect(redirect), .redirect_dir(redirect_dir), .redirect_idx(redirect_idx),
    .count(count)
  );

  typedef struct {
    logic [2:0]  idx;
    logic [6:0]  rs1;
    logic [63:0] pl;
  } exp_t;

  typedef struct {
    logic [6:0]  rs1;
    logic [63:0] pl;
    logic [3:0]  cnt;
    logic        rdy;
  } fill_t;

  exp_t  exp_q[$];
  fill_t tbl [9];
  int    nvec = 0;
  int    nmis = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_issue: got idx %0d rs1 %0d, expected no issue", issue_idx, issue_rs1);
      end else begin
        e = exp_q.pop_front();
        check("issue_idx", 64'(issue_idx), 64'(e.idx));
        check("issue_rs1", 64'(issue_rs1), 64'(e.rs1));
        check("issue_payload", issue_payload, e.pl);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic v1, input logic [6:0] r, input logic d, input logic [5:0] ri,
                     input logic [63:0] pl);
    enq_valid = 1'b1; enq_rs1v = v1; enq_rs1 = r;
    enq_rob_dir = d; enq_rob_idx = ri; enq_payload = pl;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic free(input logic [2:0] i);
    success_en = 1'b1; success_idx = i;
    tick();
    success_en = 1'b0;
  endtask

  task automatic wake(input int p, input logic [6:0] r);
    wb_en = 4'(1 << p);
    wb_rd[p*7 +: 7] = r;
    tick();
    wb_en = '0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check(nm, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    enq_valid = 0; enq_rs1v = 0; enq_rs1 = '0; enq_rob_dir = 0; enq_rob_idx = '0;
    enq_payload = '0; wb_en = '0; wb_rd = '0; issue_ready = 1'b1;
    reply_en = 0; reply_slow = 0; reply_idx = '0; success_en = 0; success_idx = '0;
    redirect = 0; redirect_dir = 0; redirect_idx = '0;
    for (int i = 0; i < 9; i++) begin
      tbl[i].rs1 = 7'(60 + i);
      tbl[i].pl  = 64'(4096 + i);
      tbl[i].cnt = 4'((i < 8) ? i + 1 : 8);
      tbl[i].rdy = (i < 7);
    end

    rst = 1'b1;
    repeat (3) tick();
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_issue_idx", 64'(issue_idx), 64'd0);
    check("rst_issue_rs1", 64'(issue_rs1), 64'd0);
    check("rst_issue_payload", issue_payload, 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_enq_ready", 64'(enq_ready), 64'd1);
    rst = 1'b0;
    tick();

    // Oldest-first: C reuses slot0 but is younger than B in slot1
    enq(1'b0, 7'd20, 1'b0, 6'd5, 64'hA);
    enq(1'b0, 7'd20, 1'b0, 6'd3, 64'hB);
    free(3'd0);
    enq(1'b0, 7'd20, 1'b0, 6'd9, 64'hC);
    check("age_count", 64'(count), 64'd2);
    exp_q.push_back('{idx: 3'd1, rs1: 7'd20, pl: 64'hB});
    exp_q.push_back('{idx: 3'd0, rs1: 7'd20, pl: 64'hC});
    wake(0, 7'd20);
    drain("age_drain");
    free(3'd1);
    free(3'd0);

    // Same-cycle enqueue wakeup
    wb_en = 4'b0100;
    wb_rd[20:14] = 7'd12;
    enq(1'b0, 7'd12, 1'b0, 6'd1, 64'hD);
    wb_en = '0;
    check("enqwake_early", 64'(issue_valid), 64'd0);
    exp_q.push_back('{idx: 3'd0, rs1: 7'd12, pl: 64'hD});
    tick();
    check("enqwake_valid", 64'(issue_valid), 64'd1);
    check("enqwake_rs1", 64'(issue_rs1), 64'd12);
    drain("enqwake_drain");
    free(3'd0);

    // Backpressure with three ready entries
    issue_ready = 1'b0;
    enq(1'b1, 7'd40, 1'b0, 6'd1, 64'hE0);
    enq(1'b1, 7'd41, 1'b0, 6'd2, 64'hE1);
    enq(1'b1, 7'd42, 1'b0, 6'd3, 64'hE2);
    exp_q.push_back('{idx: 3'd0, rs1: 7'd40, pl: 64'hE0});
    exp_q.push_back('{idx: 3'd1, rs1: 7'd41, pl: 64'hE1});
    exp_q.push_back('{idx: 3'd2, rs1: 7'd42, pl: 64'hE2});
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 64'(issue_valid), 64'd1);
      check("bp_idx", 64'(issue_idx), 64'd0);
      check("bp_payload", issue_payload, 64'hE0);
      check("bp_count", 64'(count), 64'd3);
      tick();
    end
    issue_ready = 1'b1;
    drain("bp_drain");

    // Slow replay of entry 2
    reply_en = 1'b1; reply_slow = 1'b1; reply_idx = 3'd2;
    exp_q.push_back('{idx: 3'd2, rs1: 7'd42, pl: 64'hE2});
    tick();
    reply_en = 1'b0; reply_slow = 1'b0;
    check("replay_gap", 64'(issue_valid), 64'd0);
    for (int k = 0; k < BK; k++) begin
      tick();
      check("replay_backoff", 64'(issue_valid), 64'd0);
    end
    tick();
    check("replay_valid", 64'(issue_valid), 64'd1);
    check("replay_idx", 64'(issue_idx), 64'd2);
    drain("replay_drain");

    // Success beats reply on the same entry
    success_en = 1'b1; success_idx = 3'd0; reply_en = 1'b1; reply_idx = 3'd0;
    tick();
    success_en = 1'b0; reply_en = 1'b0;
    repeat (3) tick();
    check("succ_reply_count", 64'(count), 64'd2);
    free(3'd1);
    free(3'd2);
    check("empty_count", 64'(count), 64'd0);

    // Redirect across a ROB wrap
    issue_ready = 1'b0;
    enq(1'b0, 7'd50, 1'b0, 6'd60, 64'hF0);
    enq(1'b0, 7'd51, 1'b1, 6'd2, 64'hF1);
    enq(1'b1, 7'd52, 1'b1, 6'd5, 64'hF2);
    tick();
    check("redir_pre_valid", 64'(issue_valid), 64'd1);
    check("redir_pre_idx", 64'(issue_idx), 64'd2);
    redirect = 1'b1; redirect_dir = 1'b1; redirect_idx = 6'd2;
    enq_valid = 1'b1; enq_rs1v = 1'b1; enq_rs1 = 7'd53;
    tick();
    redirect = 1'b0; enq_valid = 1'b0;
    check("redir_count", 64'(count), 64'd2);
    check("redir_issue_valid", 64'(issue_valid), 64'd0);
    issue_ready = 1'b1;
    exp_q.push_back('{idx: 3'd1, rs1: 7'd51, pl: 64'hF1});
    wake(1, 7'd51);
    drain("redir_drain");
    free(3'd0);
    free(3'd1);

    // Full boundary from the vector table
    for (int i = 0; i < 9; i++) begin
      enq(1'b0, tbl[i].rs1, 1'b0, 6'(i), tbl[i].pl);
      check("fill_count", 64'(count), 64'(tbl[i].cnt));
      check("fill_enq_ready", 64'(enq_ready), 64'(tbl[i].rdy));
    end
    free(3'd3);
    check("freed_enq_ready", 64'(enq_ready), 64'd1);
    check("freed_count", 64'(count), 64'd7);
    enq(1'b0, 7'd100, 1'b0, 6'd20, 64'h5A5A);
    check("reuse_count", 64'(count), 64'd8);
    exp_q.push_back('{idx: 3'd3, rs1: 7'd100, pl: 64'h5A5A});
    wake(3, 7'd100);
    drain("reuse_drain");
    wake(2, 7'd68);
    repeat (3) tick();

    // Reset asserted mid-operation
    issue_ready = 1'b0;
    wake(0, 7'd60);
    tick();
    check("pre_rst_valid", 64'(issue_valid), 64'd1);
    check("pre_rst_rs1", 64'(issue_rs1), 64'd60);
    rst = 1'b1;
    #2;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_enq_ready", 64'(enq_ready), 64'd1);
    check("mid_rst_issue_valid", 64'(issue_valid), 64'd0);
    check("mid_rst_issue_idx", 64'(issue_idx), 64'd0);
    check("mid_rst_payload", issue_payload, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
